csa_operand_accumulator: RTL and testbench

Multi-operand front end for the 32-bit carry-save adder stage (wholeoperation). Accepts a stream of 32-bit operands over a valid/ready handshake. Compresses each operand into a registered redundant pair (sum vector, carry vector) with a 3:2 carry-save row. On the last operand of a group, presents the pair to the downstream adder as x/y/cin and holds it until the consumer accepts it.

---
 rtl/csa_pkg.sv | 20 ++
 rtl/csa_row32.sv | 22 ++
 rtl/csa_operand_accumulator.sv | 101 ++++++++++
 tb/tb_csa_operand_accumulator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types for the carry-save adder front end: word type, accumulator
// states and the redundant (sum, carry) pair.
package csa_pkg;

   localparam int WIDTH = 32;

   typedef logic [WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      PRESENT = 2'd2
   } state_t;

   typedef struct packed {
      word_t s;
      word_t c;
   } csa_pair_t;

endpackage

// File: rtl/csa_row32.sv
// Combinational 3:2 carry-save row: folds operand d into the redundant pair
// (s, c). Reusable as one level of a wider CSA tree.
module csa_row32
   import csa_pkg::*;
#(
   parameter int W = csa_pkg::WIDTH
) (
   input  logic [W-1:0] s,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic [W-1:0] s_nxt,
   output logic [W-1:0] c_nxt
);

   logic [W-1:0] maj;

   assign s_nxt = s ^ c ^ d;
   assign maj   = (s & c) | (s & d) | (c & d);
   // Carry out of the top bit falls off: the pair is modulo 2**W.
   assign c_nxt = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_operand_accumulator.sv
// Accumulates a stream of operands into a registered sum/carry pair and
// hands the pair to the downstream adder once per group.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | pair and count cleared, waiting for the first operand
//   ACCUM   | at least one operand folded in, waiting for last/saturation
//   PRESENT | pair held on out_*, waiting for out_ready
module csa_operand_accumulator
   import csa_pkg::*;
#(
   parameter int WIDTH = csa_pkg::WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic             out_cin,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}} - CNT_ONE;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] s_q, c_q;
   logic [WIDTH-1:0] s_row, c_row;
   logic [CNT_W-1:0] cnt_q;
   logic             sat_q;
   logic             take, give, hit_max;

   csa_row32 #(.W(WIDTH)) u_row (
      .s     (s_q),
      .c     (c_q),
      .d     (in_data),
      .s_nxt (s_row),
      .c_nxt (c_row)
   );

   assign in_ready  = (state != PRESENT);
   assign out_valid = (state == PRESENT);
   assign take      = in_valid && in_ready;
   assign give      = out_valid && out_ready;
   // The operand being taken now would be the last one the counter can hold.
   assign hit_max   = (cnt_q == CNT_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: begin
            if (take) begin
               state_nxt = (in_last || hit_max) ? PRESENT : ACCUM;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s_q   <= '0;
         c_q   <= '0;
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take) begin
            s_q   <= s_row;
            c_q   <= c_row;
            cnt_q <= cnt_q + CNT_ONE;
            sat_q <= hit_max && !in_last;
         end else if (give) begin
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
         end
      end
   end

   assign out_x     = s_q;
   assign out_y     = c_q;
   assign out_cin   = 1'b0;
   assign out_count = cnt_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_csa_operand_accumulator.sv
// Randomised scoreboard bench for csa_operand_accumulator with a small
// counter (CNT_W=2) so that saturation is exercised often.
module tb_csa_operand_accumulator;

   localparam int W    = 32;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_last;
   logic [W-1:0]  in_data;
   logic          out_valid, out_ready, out_cin, out_sat;
   logic [W-1:0]  out_x, out_y;
   logic [CW-1:0] out_count;

   csa_operand_accumulator #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_cin   (out_cin),
      .out_count (out_count),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      int           cnt;
      bit           sat;
      logic [W-1:0] first;
   } exp_t;

   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] m_acc = '0;
   logic [W-1:0] m_first = '0;
   int           m_cnt = 0;
   bit           rdy_force = 1'b1;
   bit           rdy_val = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         out_ready = rdy_force ? rdy_val : ($urandom_range(3) != 0);
      end
   end

   // Monitor: samples 3 time units after the falling edge, pops on handshake.
   initial begin
      exp_t         e;
      logic [W-1:0] sm;
      forever begin
         @(negedge clk);
         #3;
         if (rst !== 1'b0) continue;
         if (out_valid === 1'b1) check("in_ready_low_while_present", {63'd0, in_ready}, 64'd0);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("pair_expected", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
               e  = sb.pop_front();
               sm = out_x + out_y + {31'd0, out_cin};
               check("pair_sum",   {32'd0, sm}, {32'd0, e.sum});
               check("pair_count", {62'd0, out_count}, 64'(e.cnt));
               check("pair_sat",   {63'd0, out_sat}, {63'd0, e.sat});
               check("pair_cin",   {63'd0, out_cin}, 64'd0);
               if (e.cnt == 1) begin
                  check("single_x", {32'd0, out_x}, {32'd0, e.first});
                  check("single_y", {32'd0, out_y}, 64'd0);
               end
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input bit last);
      int waited;
      bit ended;
      waited = 0;
      ended  = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      #3;
      while (in_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         #3;
         waited++;
      end
      if (in_ready !== 1'b1) begin
         check("in_ready_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      if (m_cnt == 0) m_first = d;
      m_acc = m_acc + d;
      m_cnt++;
      if (last || m_cnt == MAXC) begin
         sb.push_back('{sum: m_acc, cnt: m_cnt, sat: !last, first: m_first});
         m_acc = '0;
         m_cnt = 0;
         ended = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = $urandom;
      if (ended) begin
         @(negedge clk);
         #3;
         check("latency_out_valid", {63'd0, out_valid}, 64'd1);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"},  {63'd0, in_ready}, 64'd1);
      check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      check({tag, "_out_x"},     {32'd0, out_x}, 64'd0);
      check({tag, "_out_y"},     {32'd0, out_y}, 64'd0);
      check({tag, "_out_cin"},   {63'd0, out_cin}, 64'd0);
      check({tag, "_out_count"}, {62'd0, out_count}, 64'd0);
      check({tag, "_out_sat"},   {63'd0, out_sat}, 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_acc = '0;
      m_cnt = 0;
      #3;
   endtask

   initial begin
      logic [W-1:0] sm;
      int           waited;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #3;
      check_idle_outputs("reset");

      send(32'd10, 1'b0);
      send(32'd11, 1'b1);
      send(32'hFFFF_FFFF, 1'b0);
      send(32'd1, 1'b0);
      send(32'd1, 1'b1);
      send(32'd4234234, 1'b1);

      // Back-pressure: pair 855+100 held while an operand waits upstream.
      rdy_val = 1'b0;
      send(32'd855, 1'b0);
      send(32'd100, 1'b1);
      in_valid = 1'b1;
      in_data  = 32'd1111;
      repeat (5) begin
         sm = out_x + out_y;
         check("bp_in_ready", {63'd0, in_ready}, 64'd0);
         check("bp_out_valid", {63'd0, out_valid}, 64'd1);
         check("bp_sum", {32'd0, sm}, 64'd955);
         @(negedge clk);
         #3;
      end
      in_valid = 1'b0;
      rdy_val  = 1'b1;
      send(32'd1111, 1'b0);
      send(32'd112, 1'b1);

      // Saturation: four operands without last; the fourth opens a new group.
      repeat (4) send(32'd1, 1'b0);
      send(32'd1, 1'b1);

      // Reset mid-group discards the partial pair.
      send(32'd423434524, 1'b0);
      do_reset();
      check_idle_outputs("midreset");
      send(32'd532523523, 1'b1);

      rdy_force = 1'b0;
      for (int i = 0; i < 300; i++) begin
         send($urandom, $urandom_range(3) == 0);
         if ($urandom_range(7) == 0) begin
            @(negedge clk);
            in_last = 1'b1;
            in_data = $urandom;
            @(negedge clk);
            in_last = 1'b0;
         end
         if ($urandom_range(49) == 0) do_reset();
      end
      send(32'd5, 1'b1);

      rdy_force = 1'b1;
      rdy_val   = 1'b1;
      waited    = 0;
      while (sb.size() != 0 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
